// File: rtl/beaker8_pkg.sv
// Beaker8 shared definitions: boot ROM window geometry and the fetch queue entry.
package beaker8_pkg;

  localparam int          ROM_ADDR_W      = 14;
  localparam logic [15:0] ROM_WINDOW_MASK = 16'hC000;
  localparam logic [15:0] BOOT_VECTOR     = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } fetch_entry_t;

  // True when pc addresses a byte inside the 16 KB boot ROM.
  function automatic logic in_rom_window(input logic [15:0] pc);
    return (pc & ROM_WINDOW_MASK) == 16'h0000;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer of {pc, byte} pairs.
// The head is read straight from the storage registers, so it is stable
// for as long as it is not popped. Flush empties the queue in one cycle.
module fetch_fifo
  import beaker8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_wr_entry,
  input  logic         i_pop,
  output fetch_entry_t o_rd_entry,
  output logic         o_full,
  output logic         o_empty
);

  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Entry storage; cleared on reset so the head reads as zero while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_entry;
    end else begin
      r_mem <= r_mem;
    end
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= i_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
      r_rd_ptr <= i_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_entry = r_mem[r_rd_ptr];
  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Beaker8 instruction fetch stage. Reads one byte per cycle from the boot ROM
// (combinational read) into a small {pc, byte} queue feeding the decoder.
// Redirect flushes and restarts fetch; halt stalls fetch while the queue drains;
// a fetch pc outside the ROM window raises fault and stops fetching.
module instr_prefetch
  import beaker8_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = BOOT_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  rom_cs,
  output logic [ROM_ADDR_W-1:0] rom_address,
  input  logic [7:0]            rom_data,
  output logic [7:0]            out_data,
  output logic [15:0]           out_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  redirect,
  input  logic [15:0]           redirect_pc,
  input  logic                  halt,
  output logic                  fault
);

  logic [15:0]  r_fetch_pc;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_fetch_en;
  logic         w_fault;

  // Fault is a pure function of the fetch pc, so a redirect back into the
  // window clears it on the following cycle without any extra state.
  assign w_fault    = !reset && !in_rom_window(r_fetch_pc);
  assign out_valid  = !w_empty;
  // A pop coinciding with redirect is dropped by the flush anyway.
  assign w_pop      = out_valid && out_ready && !redirect;
  // A full queue can still accept a byte when the head leaves this cycle.
  assign w_fetch_en = !reset && !halt && !redirect && !w_fault && (!w_full || w_pop);

  assign rom_cs      = w_fetch_en;
  assign rom_address = r_fetch_pc[ROM_ADDR_W-1:0];
  assign fault       = w_fault;
  assign w_wr_entry  = '{pc: r_fetch_pc, data: rom_data};
  assign out_data    = w_head.data;
  assign out_pc      = w_head.pc;

  // Fetch pc: redirect wins, otherwise advance by one per accepted byte (modulo 2^16).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_fetch_en) begin
      r_fetch_pc <= r_fetch_pc + 16'd1;
    end else begin
      r_fetch_pc <= r_fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (redirect),
    .i_push     (w_fetch_en),
    .i_wr_entry (w_wr_entry),
    .i_pop      (w_pop),
    .o_rd_entry (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed table, corner-case
// sequences and random traffic, all checked against a queue-based model.
module tb_instr_prefetch;
  import beaker8_pkg::*;

  localparam int DEPTH     = 4;
  localparam int ROM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_cs;
  logic [13:0] rom_address;
  logic [7:0]  rom_data;
  logic [7:0]  out_data;
  logic [15:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        fault;

  logic [7:0] rom [ROM_BYTES];

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        exp_cs;
    logic        exp_v;
    logic [15:0] exp_pc;
  } vec_t;

  ent_t        m_q[$];
  int unsigned m_pc;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl [20];

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_cs      (rom_cs),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .out_data    (out_data),
    .out_pc      (out_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_cs ? rom[rom_address] : 8'h00;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a fetch is possible when not halted/redirected, pc is in the ROM,
  // and there is room in the queue (or the head leaves this cycle).
  function automatic bit model_cs();
    return !halt && !redirect && (m_pc < ROM_BYTES) &&
           ((m_q.size() < DEPTH) || (m_q.size() > 0 && out_ready));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc = 0;
  endtask

  task automatic model_edge();
    ent_t e;
    bit   do_pop;
    bit   do_push;
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      do_pop  = (m_q.size() > 0) && out_ready;
      do_push = model_cs();
      if (do_pop) e = m_q.pop_front();
      if (do_push) begin
        e.pc   = 16'(m_pc);
        e.data = rom[m_pc % ROM_BYTES];
        m_q.push_back(e);
        m_pc = (m_pc + 1) % 65536;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"},    32'(out_valid),   32'(m_q.size() > 0));
    chk({tag, " rom_cs"},   32'(rom_cs),      32'(model_cs()));
    chk({tag, " fault"},    32'(fault),       32'(m_pc >= ROM_BYTES));
    chk({tag, " rom_addr"}, 32'(rom_address), m_pc % ROM_BYTES);
    if (m_q.size() > 0) begin
      chk({tag, " out_pc"},   32'(out_pc),   32'(m_q[0].pc));
      chk({tag, " out_data"}, 32'(out_data), 32'(m_q[0].data));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rom_cs"},    32'(rom_cs),    32'h0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " fault"},     32'(fault),     32'h0);
    chk({tag, " out_pc"},    32'(out_pc),    32'h0);
    chk({tag, " out_data"},  32'(out_data),  32'h0);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic rd, input logic [15:0] rpc, input logic h);
    out_ready   = r;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = h;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic rd, input logic [15:0] rpc,
                      input logic h, input string tag);
    drive(r, rd, rpc, h);
    check_model(tag);
    tick();
  endtask

  initial begin
    logic [15:0] rpc;
    int          sel;

    for (int i = 0; i < ROM_BYTES; i++) begin
      rom[i] = 8'((i * 37) ^ (i >> 6) ^ 8'h5A);
    end
    rom[0] = 8'hF3; rom[1] = 8'h10; rom[2] = 8'h04;
    rom[3] = 8'h3E; rom[4] = 8'hA5; rom[5] = 8'hC9;

    // Rows 0-3: stream; 4-13: decoder stalls (queue fills after 3 more fetches); 14-19: release.
    for (int i = 0; i < 20; i++) begin
      tbl[i].rdy    = !(i >= 4 && i <= 13);
      tbl[i].exp_cs = !(i >= 7 && i <= 13);
      tbl[i].exp_v  = (i != 0);
      tbl[i].exp_pc = (i <= 3) ? 16'(i - 1) : ((i <= 13) ? 16'h0003 : 16'(i - 11));
    end

    reset = 1'b1;
    out_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    reset = 1'b0;

    // Tests 1 and 2: streaming start-up, full-queue stall and release.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rdy, 1'b0, 16'h0000, 1'b0);
      check_model("tbl");
      chk($sformatf("tbl[%0d] rom_cs", i), 32'(rom_cs), 32'(tbl[i].exp_cs));
      chk($sformatf("tbl[%0d] valid", i),  32'(out_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk($sformatf("tbl[%0d] out_pc", i),   32'(out_pc),   32'(tbl[i].exp_pc));
        chk($sformatf("tbl[%0d] out_data", i), 32'(out_data), 32'(rom[tbl[i].exp_pc[13:0]]));
      end
      tick();
    end

    // Test 3: redirect while full and popping.
    step(1'b1, 1'b1, 16'h0004, 1'b0, "t3 redir");
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t3 a");
    chk("t3 bubble valid", 32'(out_valid), 32'h0);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t3 b");
    chk("t3 first valid", 32'(out_valid), 32'h1);
    chk("t3 first pc", 32'(out_pc), 32'h0004);
    tick();
    repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0, "t3 run");

    // Test 4: run off the end of the ROM window, then recover.
    step(1'b1, 1'b1, 16'h3FFE, 1'b0, "t4 redir");
    step(1'b1, 1'b0, 16'h0000, 1'b0, "t4 s1");
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t4 s2");
    chk("t4 pc 3FFE", 32'(out_pc), 32'h3FFE);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t4 s3");
    chk("t4 pc 3FFF", 32'(out_pc), 32'h3FFF);
    chk("t4 fault set", 32'(fault), 32'h1);
    chk("t4 cs off", 32'(rom_cs), 32'h0);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t4 s4");
    chk("t4 drained", 32'(out_valid), 32'h0);
    chk("t4 fault held", 32'(fault), 32'h1);
    tick();
    step(1'b1, 1'b1, 16'h0000, 1'b0, "t4 redir0");
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t4 s5");
    chk("t4 fault cleared", 32'(fault), 32'h0);
    chk("t4 cs resumed", 32'(rom_cs), 32'h1);
    tick();
    step(1'b1, 1'b0, 16'h0000, 1'b0, "t4 s6");

    // Test 5: halt with three bytes queued.
    step(1'b0, 1'b1, 16'h0100, 1'b0, "t5 redir");
    repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0, "t5 fill");
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      check_model("t5 halt");
      chk("t5 halt cs", 32'(rom_cs), 32'h0);
      chk("t5 halt valid", 32'(out_valid), (k < 3) ? 32'h1 : 32'h0);
      if (k < 3) chk("t5 halt pc", 32'(out_pc), 32'h0100 + 32'(k));
      tick();
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t5 resume");
    chk("t5 frozen addr", 32'(rom_address), 32'h0103);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t5 cont");
    chk("t5 continuous pc", 32'(out_pc), 32'h0103);
    tick();

    // Test 6: asynchronous reset between clock edges.
    repeat (2) step(1'b1, 1'b0, 16'h0000, 1'b0, "t6 pre");
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t6 pre2");
    #1 reset = 1'b1;
    #1 check_reset("t6 async");
    @(posedge clk);
    @(negedge clk);
    model_reset();
    #1 check_reset("t6 held");
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 16'h0000, 1'b0, "t6 rel");
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("t6 restart");
    chk("t6 restart pc", 32'(out_pc), 32'h0000);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: rpc = 16'($urandom_range(0, ROM_BYTES - 1));
        6, 7:             rpc = 16'h3FF0 + 16'($urandom_range(0, 15));
        8:                rpc = 16'h4000 | 16'($urandom);
        default:          rpc = 16'h0000;
      endcase
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 4), rpc,
           ($urandom_range(0, 9) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
